fetch_queue: RTL
================

# fetch_queue

Instruction prefetch buffer between the combinational instruction memory and the fetch-to-decode pipeline register. It owns the fetch PC, issues one word address per cycle, and stores {PC, instruction} pairs in a small FIFO. It presents them to decode with a valid/ready handshake, so a decode stall no longer freezes the program counter. On a taken branch, jump, JALR or RET it discards all buffered instructions and restarts fetch at the redirect target.

## Interface
Parameters:
- WIDTH, 32, data/address width
- DEPTH, 4, FIFO entries; power of two, minimum 2
- RESET_PC, 32'h0, fetch PC loaded on reset

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- redirect  input  1  flush queue and restart fetch (PCsrc != 00 in execute)
- redirect_pc  input  WIDTH  new fetch target; bits [1:0] forced to 0
- halt  input  1  stop issuing new fetches (exit instruction decoded)
- imem_addr  output  WIDTH  current fetch PC, to instruction memory
- imem_instr  input  WIDTH  instruction word at imem_addr, same cycle
- dec_ready  input  1  decode accepts head entry (= !stall)
- dec_valid  output  1  head entry valid
- dec_instr  output  WIDTH  head instruction; 32'h0 when !dec_valid
- dec_pc  output  WIDTH  head PC; 0 when !dec_valid
- dec_pcplus4  output  WIDTH  dec_pc + 4; 0 when !dec_valid
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch_pc register, storage array[DEPTH] of {pc, instr}, read and write pointers (mod DEPTH), and count.
- pop = dec_valid & dec_ready.
- push = !halt & !redirect & (count < DEPTH | pop). Full queue with simultaneous pop accepts a push.
- On push: write {fetch_pc, imem_instr} at the write pointer, advance the write pointer, fetch_pc += 4 (wraps modulo 2^WIDTH).
- On pop: advance the read pointer.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- dec_valid = (count != 0). Outputs come from the head entry; show-ahead, no read latency.
- Priority order: rst > redirect > push/pop.
- Redirect (single cycle): pointers and count cleared, fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00}. The pop in that cycle is still taken as handshaked, but the entry is discarded.
- Halt: fetch_pc holds and no push occurs; buffered entries keep draining. Redirect during halt still flushes and loads fetch_pc.
- imem_addr = fetch_pc at all times.
- Reset values: fetch_pc = RESET_PC, count = 0, pointers = 0, dec_valid = 0, dec_instr/dec_pc/dec_pcplus4 = 0, imem_addr = RESET_PC.

## Timing
- Fill latency: the instruction at fetch_pc in cycle N is visible on dec_* in cycle N+1 (one cycle from reset release or from redirect to first dec_valid).
- Redirect asserted in cycle N: dec_valid = 0 in N+1; the target instruction appears in N+2.
- Throughput: one instruction per cycle once filled, including while full with dec_ready held high.
- dec_ready held low: the queue fills to DEPTH within DEPTH cycles, then fetch_pc holds.
- dec_* hold stable while dec_valid & !dec_ready.

## Configuration
- FETCHQ_BYPASS_EN defined: when count == 0, !halt and !redirect, the block drives dec_valid = 1 and dec_* = {fetch_pc, imem_instr} combinationally in the same cycle.
  - If dec_ready, the word is consumed without being stored and fetch_pc advances.
  - Otherwise it is pushed as normal.
  - Fill and redirect latencies each shrink by one cycle.
- FETCHQ_BYPASS_EN undefined: dec_* always come from storage, with the latencies listed above.

## Test plan
- Reset, then dec_ready = 1 with imem returning addr^32'hA5A5_0000: dec_pc = 0, 4, 8… in consecutive cycles from cycle 1, and each dec_instr matches its PC; count stays at 1.
- dec_ready = 0 for 6 cycles with DEPTH = 4: count reaches 4 by cycle 4, imem_addr holds at 0x10, and dec_pc stays 0. Release dec_ready: PCs 0, 4, 8, 0xC, 0x10 issue back-to-back.
- Queue full with pop and push in the same cycle: count stays 4 and the new entry (pc 0x10) lands after 0xC with no loss or duplication.
- Redirect with redirect_pc = 0x103 while 3 entries are queued: the next cycle has count = 0 and dec_valid = 0; the following cycle has dec_pc = 0x100 and dec_pcplus4 = 0x104.
- Halt asserted with 2 entries queued and dec_ready = 1: both drain, then dec_valid = 0 and imem_addr stays frozen. Redirect to 0x40 during halt: imem_addr = 0x40 and no push occurs.
- rst asserted mid-stream with a redirect in the same cycle: imem_addr = RESET_PC, count = 0, and the redirect is ignored.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC and buffers {pc, instr} pairs for decode.
// Define FETCHQ_BYPASS_EN to forward the fetched word straight to decode when the queue is empty.
module fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    input  logic                     halt,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic [WIDTH-1:0]         imem_instr,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [WIDTH-1:0]         dec_instr,
    output logic [WIDTH-1:0]         dec_pc,
    output logic [WIDTH-1:0]         dec_pcplus4,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [WIDTH-1:0] fetchPc;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;
    logic             headValid;
    logic [WIDTH-1:0] outPc;
    logic [WIDTH-1:0] outInstr;

    assign head      = mem[rdPtr];
    assign headValid = (cnt != '0);

    always_comb begin
        dec_valid = headValid;
        outPc     = head.pc;
        outInstr  = head.instr;
`ifdef FETCHQ_BYPASS_EN
        // Empty queue: present the word being fetched right now. A consumed bypass
        // word is a simultaneous push and pop, so the count stays at zero.
        if (!headValid && !halt && !redirect) begin
            dec_valid = 1'b1;
            outPc     = fetchPc;
            outInstr  = imem_instr;
        end
`endif
    end

    assign pop  = dec_valid & dec_ready;
    assign push = !halt && !redirect && (cnt < FULL || pop);

    assign imem_addr   = fetchPc;
    assign dec_pc      = dec_valid ? outPc : '0;
    assign dec_instr   = dec_valid ? outInstr : '0;
    assign dec_pcplus4 = dec_valid ? outPc + WIDTH'(4) : '0;
    assign count       = cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= '{pc: fetchPc, instr: imem_instr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            cnt     <= '0;
        end else if (redirect) begin
            // Flush: any handshaked pop this cycle is dropped along with the rest.
            fetchPc <= redirect_pc & ~WIDTH'(3);
            rdPtr   <= '0;
            wrPtr   <= '0;
            cnt     <= '0;
        end else begin
            if (push) begin
                wrPtr   <= wrPtr + PW'(1);
                fetchPc <= fetchPc + WIDTH'(4);
            end
            if (pop) rdPtr <= rdPtr + PW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    aCntBound: assert property (@(posedge clk) disable iff (rst) cnt <= FULL);
    aHoldStall: assert property (@(posedge clk) disable iff (rst)
        (dec_valid && !dec_ready && !redirect) |=> ($stable(dec_pc) && $stable(dec_instr)));

endmodule
